// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encodings, the registered
// control-output bundle, and the width of the lock-loss counter.
package ct_clk_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   localparam int LOCK_LOSS_W = 8;

   typedef struct packed {
      logic pll_rst;
      logic sys_rst;
      logic ready;
      logic fail;
   } ctl_t;

   // Control outputs are a pure function of the state they will accompany.
   function automatic ctl_t ctl_for(state_t st);
      ctl_t c;
      c.pll_rst = (st == ST_PLL_RST);
      c.sys_rst = (st != ST_RUN);
      c.ready   = (st == ST_RUN);
      c.fail    = (st == ST_FAIL);
      return c;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the lock supervisor (master) and the PLL plus the
// downstream reset consumers (slave).
interface pll_lock_supervisor_if;
   import ct_clk_pkg::*;

   logic                   locked;
   logic                   pll_rst;
   logic                   sys_rst;
   logic                   ready;
   logic                   fail;
   logic [2:0]             state_o;
   logic [LOCK_LOSS_W-1:0] lock_loss_cnt;

   modport master (
      input  locked,
      output pll_rst, sys_rst, ready, fail, state_o, lock_loss_cnt
   );

   modport slave (
      output locked,
      input  pll_rst, sys_rst, ready, fail, state_o, lock_loss_cnt
   );
endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchroniser for asynchronous level inputs, one independent chain
// per bit, cleared by a synchronous active-high reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk) begin
            if (srst) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies lock (timeout, bounded retries, stability
// window) and only then releases the downstream system reset.
module pll_lock_supervisor
   import ct_clk_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int RETRY_MAX      = 3,
   parameter int CNT_W          = 16
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_supervisor_if.master bus
);

   localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

   // The counter only ever reaches (limit-1), so each limit may equal 2**CNT_W.
   generate
      if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_limits
         $error("pll_lock_supervisor: cycle limits must be at least 1");
      end
      if (CNT_W < 1 || CNT_W > 30 ||
          PLL_RST_CYCLES > (1 << CNT_W) ||
          LOCK_TIMEOUT   > (1 << CNT_W) ||
          STABLE_CYCLES  > (1 << CNT_W)) begin : g_bad_cnt_w
         $error("pll_lock_supervisor: CNT_W too small for the configured cycle limits");
      end
      if (RETRY_MAX < 0) begin : g_bad_retry
         $error("pll_lock_supervisor: RETRY_MAX must be non-negative");
      end
   endgenerate

   logic                   lk;
   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [RETRY_W-1:0]     retry_reg, retry_next;
   logic [LOCK_LOSS_W-1:0] loss_reg, loss_next;
   ctl_t                   ctl_reg, ctl_next;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk  (refclk),
      .srst (rst),
      .d    (bus.locked),
      .q    (lk)
   );

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_reg <= ST_PLL_RST;
         cnt_reg   <= '0;
         retry_reg <= '0;
         loss_reg  <= '0;
         ctl_reg   <= ctl_for(ST_PLL_RST);
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         retry_reg <= retry_next;
         loss_reg  <= loss_next;
         ctl_reg   <= ctl_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      retry_next = retry_reg;
      loss_next  = loss_reg;
      cnt_next   = cnt_reg + CNT_W'(1);

      case (state_reg)
         ST_PLL_RST: begin
            if (cnt_reg == CNT_W'(PLL_RST_CYCLES - 1)) begin
               state_next = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            // A lock seen on the timeout cycle takes precedence over a retry.
            if (lk) begin
               state_next = ST_STABLE;
            end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
               if (retry_reg < RETRY_W'(RETRY_MAX)) begin
                  retry_next = retry_reg + RETRY_W'(1);
                  state_next = ST_PLL_RST;
               end else begin
                  state_next = ST_FAIL;
               end
            end
         end
         ST_STABLE: begin
            if (!lk) begin
               state_next = ST_WAIT_LOCK;
            end else if (cnt_reg == CNT_W'(STABLE_CYCLES - 1)) begin
               state_next = ST_RUN;
               retry_next = '0;
            end
         end
         ST_RUN: begin
            cnt_next = cnt_reg;
            if (!lk) begin
               state_next = ST_PLL_RST;
               if (loss_reg != '1) begin
                  loss_next = loss_reg + LOCK_LOSS_W'(1);
               end
            end
         end
         ST_FAIL: begin
            cnt_next = cnt_reg;
         end
         default: begin
            state_next = ST_PLL_RST;
         end
      endcase

      if (state_next != state_reg) begin
         cnt_next = '0;
      end
   end

   // Outputs are computed from the next state so they move on the same edge.
   always_comb begin
      ctl_next = ctl_for(state_next);
   end

   assign bus.pll_rst       = ctl_reg.pll_rst;
   assign bus.sys_rst       = ctl_reg.sys_rst;
   assign bus.ready         = ctl_reg.ready;
   assign bus.fail          = ctl_reg.fail;
   assign bus.state_o       = state_reg;
   assign bus.lock_loss_cnt = loss_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scenario bench for pll_lock_supervisor with a cycle-level reference model of
// the lock-qualification rules, compared against every DUT output each cycle.
module tb_pll_lock_supervisor;

   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 20;
   localparam int STABLE_CYCLES  = 8;
   localparam int RETRY_MAX      = 2;

   localparam int P_RST    = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAIL   = 4;

   logic refclk;
   logic rst;
   int   checks;
   int   errors;

   pll_lock_supervisor_if bus ();

   pll_lock_supervisor #(
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .RETRY_MAX      (RETRY_MAX),
      .CNT_W          (16)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Reference model: phase, cycles spent in it, retries used, total losses,
   // and a two-sample delay line for the locked input.
   int m_phase;
   int m_elapsed;
   int m_retry;
   int m_losses;
   bit m_dly0;
   bit m_dly1;

   task automatic model_step(input bit r, input bit lock_in);
      bit lk_seen;
      int nxt;
      lk_seen = m_dly1;
      if (r) begin
         m_phase   = P_RST;
         m_elapsed = 0;
         m_retry   = 0;
         m_losses  = 0;
         m_dly0    = 1'b0;
         m_dly1    = 1'b0;
      end else begin
         nxt = m_phase;
         if (m_phase == P_RST) begin
            if (m_elapsed + 1 >= PLL_RST_CYCLES) nxt = P_WAIT;
         end else if (m_phase == P_WAIT) begin
            if (lk_seen) nxt = P_STABLE;
            else if (m_elapsed + 1 >= LOCK_TIMEOUT) begin
               if (m_retry < RETRY_MAX) begin
                  m_retry = m_retry + 1;
                  nxt = P_RST;
               end else begin
                  nxt = P_FAIL;
               end
            end
         end else if (m_phase == P_STABLE) begin
            if (!lk_seen) nxt = P_WAIT;
            else if (m_elapsed + 1 >= STABLE_CYCLES) begin
               nxt = P_RUN;
               m_retry = 0;
            end
         end else if (m_phase == P_RUN) begin
            if (!lk_seen) begin
               nxt = P_RST;
               m_losses = m_losses + 1;
            end
         end
         m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
         m_phase   = nxt;
         m_dly1    = m_dly0;
         m_dly0    = lock_in;
      end
   endtask

   // One clock: the model advances with the inputs held across the edge, and
   // every output is compared on the following falling edge.
   task automatic tick();
      logic [14:0] exp_v;
      logic [14:0] act_v;
      int          sat;
      @(posedge refclk);
      model_step(rst, bus.locked);
      @(negedge refclk);
      sat   = (m_losses > 255) ? 255 : m_losses;
      exp_v = {3'(m_phase), (m_phase == P_RST), (m_phase != P_RUN),
               (m_phase == P_RUN), (m_phase == P_FAIL), 8'(sat)};
      act_v = {bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail,
               bus.lock_loss_cnt};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL model_cycle t=%0t got state=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b loss=%0d expected %h (got %h)",
                  $time, bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready,
                  bus.fail, bus.lock_loss_cnt, exp_v, act_v);
      end
   endtask

   task automatic wait_state(input int st, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (bus.state_o == 3'(st)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.locked = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail} !== 7'b000_1100) begin
         errors++;
         $display("FAIL reset_outputs got state=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b expected 0 1 1 0 0",
                  bus.state_o, bus.pll_rst, bus.sys_rst, bus.ready, bus.fail);
      end
      checks++;
      if (bus.lock_loss_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_loss_cnt got %0d expected 0", bus.lock_loss_cnt);
      end
      $display("test_reset: state=%0d pll_rst=%b sys_rst=%b", bus.state_o, bus.pll_rst, bus.sys_rst);
   endtask

   task automatic test_clean_lock();
      int hi;
      int n;
      int seen[$];
      hi = 1;
      seen.push_back(int'(bus.state_o));
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.pll_rst) hi++;
         if (int'(bus.state_o) != seen[$]) seen.push_back(int'(bus.state_o));
      end
      bus.locked = 1'b1;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         n++;
         if (int'(bus.state_o) != seen[$]) seen.push_back(int'(bus.state_o));
         if (!bus.sys_rst) break;
      end
      checks++;
      if (hi != PLL_RST_CYCLES) begin
         errors++;
         $display("FAIL clean_pll_rst_width got %0d expected %0d", hi, PLL_RST_CYCLES);
      end
      checks++;
      if (n != 2 + STABLE_CYCLES + 1) begin
         errors++;
         $display("FAIL clean_release_latency got %0d expected %0d", n, 2 + STABLE_CYCLES + 1);
      end
      checks++;
      if (seen.size() != 4 || seen[0] != 0 || seen[1] != 1 || seen[2] != 2 || seen[3] != 3) begin
         errors++;
         $display("FAIL clean_state_sequence got %p expected 0,1,2,3", seen);
      end
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL clean_ready got %b expected 1", bus.ready);
      end
      $display("test_clean_lock: pll_rst_width=%0d release_latency=%0d", hi, n);
   endtask

   task automatic test_stable_glitch();
      bit ok;
      int seen[$];
      int since;
      int win;
      int early;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_state(P_STABLE, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL glitch_reach_stable got state=%0d expected 2", bus.state_o);
      end
      repeat (5) tick();
      bus.locked = 1'b0;
      tick();
      bus.locked = 1'b1;
      seen.push_back(int'(bus.state_o));
      since = 0;
      win = -1;
      early = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         since++;
         if (int'(bus.state_o) != seen[$]) begin
            seen.push_back(int'(bus.state_o));
            if (bus.state_o == 3'(P_STABLE)) since = 0;
            if (bus.state_o == 3'(P_RUN)) win = since;
         end
         if (bus.state_o != 3'(P_RUN) && !bus.sys_rst) early++;
         if (bus.state_o == 3'(P_RUN)) break;
      end
      checks++;
      if (seen.size() != 4 || seen[1] != 1 || seen[2] != 2 || seen[3] != 3) begin
         errors++;
         $display("FAIL glitch_state_sequence got %p expected 2,1,2,3", seen);
      end
      checks++;
      if (win != STABLE_CYCLES) begin
         errors++;
         $display("FAIL glitch_fresh_window got %0d expected %0d", win, STABLE_CYCLES);
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL glitch_sys_rst_early got %0d low cycles expected 0", early);
      end
      $display("test_stable_glitch: window=%0d", win);
   endtask

   task automatic test_never_lock();
      int runs[$];
      bit cur;
      int len;
      int bad;
      bit reached;
      rst = 1'b1;
      bus.locked = 1'b0;
      tick();
      rst = 1'b0;
      cur = bus.pll_rst;
      len = 1;
      reached = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.pll_rst == cur) len++;
         else begin
            runs.push_back(len);
            cur = bus.pll_rst;
            len = 1;
         end
         if (bus.state_o == 3'(P_FAIL)) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL never_reach_fail got state=%0d expected 4", bus.state_o);
      end
      checks++;
      if (runs.size() < 5 || runs[0] != 4 || runs[1] != 20 || runs[2] != 4 ||
          runs[3] != 20 || runs[4] != 4 || runs.size() != 5) begin
         errors++;
         $display("FAIL never_pulse_pattern got %p expected 4,20,4,20,4", runs);
      end
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (bus.state_o != 3'(P_FAIL) || !bus.fail) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL never_fail_persist got %0d bad cycles expected 0", bad);
      end
      checks++;
      if ({bus.fail, bus.sys_rst, bus.pll_rst, bus.ready} !== 4'b1100) begin
         errors++;
         $display("FAIL never_fail_outputs got fail=%b sys_rst=%b pll_rst=%b ready=%b expected 1 1 0 0",
                  bus.fail, bus.sys_rst, bus.pll_rst, bus.ready);
      end
      $display("test_never_lock: pulses=%0d state=%0d", (runs.size() + 1) / 2, bus.state_o);
   endtask

   task automatic test_run_loss();
      bit ok;
      int n;
      int lost;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.locked = 1'b1;
      wait_state(P_RUN, 60, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL loss_reach_run got state=%0d expected 3", bus.state_o);
      end
      repeat ($urandom_range(0, 6)) tick();
      bus.locked = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n++;
         if (bus.sys_rst) break;
      end
      checks++;
      if (n != 3 || bus.pll_rst !== 1'b1) begin
         errors++;
         $display("FAIL loss_latency got %0d cycles pll_rst=%b expected 3 cycles pll_rst=1", n, bus.pll_rst);
      end
      checks++;
      if (bus.lock_loss_cnt !== 8'd1) begin
         errors++;
         $display("FAIL loss_first_count got %0d expected 1", bus.lock_loss_cnt);
      end
      lost = 1;
      for (int i = 1; i < 300; i++) begin
         bus.locked = 1'b1;
         wait_state(P_RUN, 60, ok);
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL loss_rerun iteration %0d got state=%0d expected 3", i, bus.state_o);
            break;
         end
         repeat ($urandom_range(0, 4)) tick();
         bus.locked = 1'b0;
         repeat (3) tick();
         lost++;
         if (lost == 254) begin
            checks++;
            if (bus.lock_loss_cnt !== 8'd254) begin
               errors++;
               $display("FAIL loss_count_254 got %0d expected 254", bus.lock_loss_cnt);
            end
         end
      end
      checks++;
      if (bus.lock_loss_cnt !== 8'd255) begin
         errors++;
         $display("FAIL loss_saturate got %0d expected 255", bus.lock_loss_cnt);
      end
      $display("test_run_loss: losses=%0d lock_loss_cnt=%0d", lost, bus.lock_loss_cnt);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bus.locked = 1'b1;
      wait_state(P_STABLE, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_reach_stable got state=%0d expected 2", bus.state_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.state_o, bus.pll_rst, bus.sys_rst, bus.fail, bus.ready, bus.lock_loss_cnt} !== {3'd0, 4'b1100, 8'd0}) begin
         errors++;
         $display("FAIL mid_reset_stable got state=%0d pll_rst=%b sys_rst=%b fail=%b ready=%b loss=%0d expected 0 1 1 0 0 0",
                  bus.state_o, bus.pll_rst, bus.sys_rst, bus.fail, bus.ready, bus.lock_loss_cnt);
      end
      bus.locked = 1'b0;
      wait_state(P_FAIL, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_reach_fail got state=%0d expected 4", bus.state_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.state_o, bus.pll_rst, bus.sys_rst, bus.fail, bus.ready, bus.lock_loss_cnt} !== {3'd0, 4'b1100, 8'd0}) begin
         errors++;
         $display("FAIL mid_reset_fail got state=%0d pll_rst=%b sys_rst=%b fail=%b ready=%b loss=%0d expected 0 1 1 0 0 0",
                  bus.state_o, bus.pll_rst, bus.sys_rst, bus.fail, bus.ready, bus.lock_loss_cnt);
      end
      $display("test_reset_mid: state=%0d fail=%b", bus.state_o, bus.fail);
   endtask

   task automatic test_coincidence();
      bit ok;
      int entries;
      int prev;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.locked = 1'b0;
      wait_state(P_WAIT, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL coin_reach_wait got state=%0d expected 1", bus.state_o);
      end
      // Lock must be sampled by the decision logic exactly on the final timeout count.
      repeat (LOCK_TIMEOUT - 3) tick();
      bus.locked = 1'b1;
      repeat (2) tick();
      checks++;
      if (bus.state_o !== 3'(P_WAIT)) begin
         errors++;
         $display("FAIL coin_before got state=%0d expected 1", bus.state_o);
      end
      tick();
      checks++;
      if (bus.state_o !== 3'(P_STABLE)) begin
         errors++;
         $display("FAIL coin_lock_wins got state=%0d expected 2", bus.state_o);
      end
      bus.locked = 1'b0;
      entries = 0;
      prev = int'(bus.state_o);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.state_o == 3'(P_RST) && prev != P_RST) entries++;
         prev = int'(bus.state_o);
         if (bus.state_o == 3'(P_FAIL)) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || entries != RETRY_MAX) begin
         errors++;
         $display("FAIL coin_retry_unchanged got %0d retries reached_fail=%b expected %0d retries", entries, ok, RETRY_MAX);
      end
      $display("test_coincidence: retries_after=%0d", entries);
   endtask

   task automatic test_random();
      int len;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int seg = 0; seg < 120; seg++) begin
         bus.locked = ~bus.locked;
         len = bus.locked ? $urandom_range(1, 30) : $urandom_range(1, 90);
         for (int i = 0; i < len; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            tick();
         end
         rst = 1'b0;
      end
      $display("test_random: final state=%0d loss=%0d", bus.state_o, bus.lock_loss_cnt);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.locked = 1'b0;
      m_phase = P_RST;
      m_elapsed = 0;
      m_retry = 0;
      m_losses = 0;
      m_dly0 = 1'b0;
      m_dly1 = 1'b0;
      test_reset();
      test_clean_lock();
      test_stable_glitch();
      test_never_lock();
      test_run_loss();
      test_reset_mid();
      test_coincidence();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at t=%0t expected completion earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule
